// File: rtl/pixel_fetch_pkg.sv
// pixel_fetch_pkg: shared types and image geometry for the SRAM pixel fetcher.
package pixel_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_R0   = 2'd1,
    S_R1   = 2'd2,
    S_R2   = 2'd3
  } fetch_state_e;

  // One buffered pixel pair, byte fields in the order they arrive from SRAM.
  typedef struct packed {
    logic [7:0] r0;
    logic [7:0] g0;
    logic [7:0] b0;
    logic [7:0] r1;
    logic [7:0] g1;
    logic [7:0] b1;
  } pair_slot_t;

  // Tag travelling alongside an outstanding SRAM read.
  typedef struct packed {
    logic       valid;
    logic [1:0] w;
    logic       slot;
  } cap_tag_t;

  localparam int unsigned IMG_W_PAIRS   = 160;
  localparam int unsigned IMG_H         = 240;
  localparam int unsigned WORDS_PER_ROW = 480;

  // 8-bit channel to the controller's 10-bit colour by repeating the top bits.
  function automatic logic [9:0] expand_colour(input logic [7:0] c);
    return {c, c[7:6]};
  endfunction

endpackage

// File: rtl/pixel_fetch_addr_gen.sv
// pixel_fetch_addr_gen: word address of (row, pair, word) in the packed image.
// Row stride is 480 words, formed as (r<<9)-(r<<5) so no multiplier is needed.
module pixel_fetch_addr_gen
  import pixel_fetch_pkg::*;
#(
  parameter logic [17:0] IMG_BASE = 18'd0
) (
  input  logic [8:0]  row_i,
  input  logic [7:0]  pair_i,
  input  logic [1:0]  word_i,
  output logic [17:0] addr_o
);

  logic [17:0] row_off;
  logic [17:0] pair_off;

  // Pure address arithmetic; pair*3 is (pair<<1)+pair.
  always_comb begin
    row_off  = {row_i, 9'd0} - {4'd0, row_i, 5'd0};
    pair_off = {9'd0, pair_i, 1'b0} + {10'd0, pair_i};
    addr_o   = IMG_BASE + row_off + pair_off + {16'd0, word_i};
  end

endmodule

// File: rtl/vga_sram_pixel_fetch.sv
// vga_sram_pixel_fetch: prefetches packed RGB pixel pairs one pair ahead into a
// two-slot ping-pong buffer and drives registered colour to the VGA controller.
// Optional build macro PIXEL_FETCH_COLOUR_BARS_EN: colour bars while iEnable=0.
//
// state  | meaning
// S_IDLE | waiting for the X coordinate to enter a new pair
// S_R0   | launching word 0 ({R0,G0}) of the target pair
// S_R1   | launching word 1 ({B0,R1})
// S_R2   | launching word 2 ({G1,B1})
module vga_sram_pixel_fetch
  import pixel_fetch_pkg::*;
#(
  parameter int          SRAM_LATENCY = 3,
  parameter logic [17:0] IMG_BASE     = 18'd0
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        iEnable,
  input  logic [9:0]  iCoord_X,
  input  logic [9:0]  iCoord_Y,
  input  logic [15:0] iSRAM_read_data,
  output logic [17:0] oSRAM_address,
  output logic        oSRAM_we_n,
  output logic [9:0]  oRed,
  output logic [9:0]  oGreen,
  output logic [9:0]  oBlue,
  output logic        oBusy
);

  localparam int TAG_DEPTH = (SRAM_LATENCY < 1) ? 1 : SRAM_LATENCY;

  fetch_state_e state_q, state_d;
  logic [7:0]   fetch_pair_q, fetch_pair_d;
  logic [8:0]   fetch_row_q, fetch_row_d;
  logic [7:0]   prev_pair_q;
  logic [17:0]  addr_q;
  logic [1:0]   word_sel;
  logic [17:0]  word_addr;
  cap_tag_t     tag_q [TAG_DEPTH];
  cap_tag_t     cap;
  pair_slot_t   slot_q [2];
  pair_slot_t   cur_slot;
  logic [1:0]   valid_q, valid_d;
  logic [9:0]   red_q, green_q, blue_q;
  logic [9:0]   red_d, green_d, blue_d;
  logic [7:0]   pix_r, pix_g, pix_b;

  logic [7:0]   cur_pair, next_pair;
  logic [8:0]   cur_row;
  logic         in_image, trigger;
`ifdef PIXEL_FETCH_COLOUR_BARS_EN
  logic [2:0]   bar_idx;
`endif

  assign cur_pair  = iCoord_X[9:2];
  assign next_pair = cur_pair + 8'd1;
  assign cur_row   = iCoord_Y[9:1];
  assign in_image  = (iCoord_X < 10'd640) && (iCoord_Y < 10'd480);
  assign trigger   = iEnable && (cur_pair != prev_pair_q) &&
                     (next_pair < 8'(IMG_W_PAIRS)) && (cur_row < 9'(IMG_H));
  assign cap       = tag_q[TAG_DEPTH-1];
  assign cur_slot  = slot_q[cur_pair[0]];

  pixel_fetch_addr_gen #(.IMG_BASE(IMG_BASE)) u_addr_gen (
    .row_i  (fetch_row_q),
    .pair_i (fetch_pair_q),
    .word_i (word_sel),
    .addr_o (word_addr)
  );

  // Fetch sequencer: one address per read state; triggers outside IDLE are dropped.
  always_comb begin
    state_d      = state_q;
    fetch_pair_d = fetch_pair_q;
    fetch_row_d  = fetch_row_q;
    word_sel     = 2'd0;
    case (state_q)
      S_IDLE: if (trigger) begin
        state_d      = S_R0;
        fetch_pair_d = next_pair;
        fetch_row_d  = cur_row;
      end
      S_R0: begin word_sel = 2'd0; state_d = S_R1;   end
      S_R1: begin word_sel = 2'd1; state_d = S_R2;   end
      S_R2: begin word_sel = 2'd2; state_d = S_IDLE; end
      default: state_d = S_IDLE;
    endcase
  end

  // Slot valid bits: set by the last word of a pair, cleared when that slot is
  // retargeted, and dropped while disabled so re-enable waits for fresh data.
  always_comb begin
    valid_d = valid_q;
    if (cap.valid && (cap.w == 2'd2)) valid_d[cap.slot] = 1'b1;
    if ((state_q == S_IDLE) && trigger) valid_d[next_pair[0]] = 1'b0;
    if (!iEnable) valid_d = 2'b00;
  end

  // Colour selection from the slot holding the pair under the beam.
  always_comb begin
    pix_r   = iCoord_X[1] ? cur_slot.r1 : cur_slot.r0;
    pix_g   = iCoord_X[1] ? cur_slot.g1 : cur_slot.g0;
    pix_b   = iCoord_X[1] ? cur_slot.b1 : cur_slot.b0;
    red_d   = 10'd0;
    green_d = 10'd0;
    blue_d  = 10'd0;
`ifdef PIXEL_FETCH_COLOUR_BARS_EN
    bar_idx = iCoord_X[9:7];
`endif
    if (iEnable && valid_q[cur_pair[0]] && in_image) begin
      red_d   = expand_colour(pix_r);
      green_d = expand_colour(pix_g);
      blue_d  = expand_colour(pix_b);
    end
`ifdef PIXEL_FETCH_COLOUR_BARS_EN
    else if (!iEnable && in_image) begin
      red_d   = {10{bar_idx[2]}};
      green_d = {10{bar_idx[1]}};
      blue_d  = {10{bar_idx[0]}};
    end
`endif
  end

  // Control state, address launch and the read-tag pipeline.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= S_IDLE;
      fetch_pair_q <= 8'd0;
      fetch_row_q  <= 9'd0;
      prev_pair_q  <= 8'd0;
      addr_q       <= 18'd0;
      valid_q      <= 2'b00;
      for (int i = 0; i < TAG_DEPTH; i++) tag_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pair_q <= fetch_pair_d;
      fetch_row_q  <= fetch_row_d;
      prev_pair_q  <= cur_pair;
      valid_q      <= valid_d;
      if (state_q != S_IDLE) addr_q <= word_addr;
      tag_q[0] <= (state_q != S_IDLE) ? '{valid: 1'b1, w: word_sel, slot: fetch_pair_q[0]}
                                      : '0;
      for (int i = 1; i < TAG_DEPTH; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Returning SRAM words land in the byte fields named by their tag.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else if (cap.valid) begin
      case (cap.w)
        2'd0: begin
          slot_q[cap.slot].r0 <= iSRAM_read_data[15:8];
          slot_q[cap.slot].g0 <= iSRAM_read_data[7:0];
        end
        2'd1: begin
          slot_q[cap.slot].b0 <= iSRAM_read_data[15:8];
          slot_q[cap.slot].r1 <= iSRAM_read_data[7:0];
        end
        2'd2: begin
          slot_q[cap.slot].g1 <= iSRAM_read_data[15:8];
          slot_q[cap.slot].b1 <= iSRAM_read_data[7:0];
        end
        default: ;
      endcase
    end
  end

  // Registered colour outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      red_q   <= 10'd0;
      green_q <= 10'd0;
      blue_q  <= 10'd0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign oSRAM_address = addr_q;
  assign oSRAM_we_n    = 1'b1;
  assign oRed          = red_q;
  assign oGreen        = green_q;
  assign oBlue         = blue_q;
  assign oBusy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_vga_sram_pixel_fetch.sv
// Bench for vga_sram_pixel_fetch: hand-built vectors for the documented corner
// cases plus a randomized raster sweep checked every clock against a
// cycle-level reference model of the prefetch rules.
`timescale 1ns/1ps
module tb_vga_sram_pixel_fetch;

  localparam int LAT = 3;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        iEnable = 1'b0;
  logic [9:0]  iCoord_X = '0;
  logic [9:0]  iCoord_Y = '0;
  logic [15:0] iSRAM_read_data;
  logic [17:0] oSRAM_address;
  logic        oSRAM_we_n;
  logic [9:0]  oRed, oGreen, oBlue;
  logic        oBusy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  vga_sram_pixel_fetch #(.SRAM_LATENCY(LAT), .IMG_BASE(18'd0)) dut (
    .Clock           (Clock),
    .Resetn          (Resetn),
    .iEnable         (iEnable),
    .iCoord_X        (iCoord_X),
    .iCoord_Y        (iCoord_Y),
    .iSRAM_read_data (iSRAM_read_data),
    .oSRAM_address   (oSRAM_address),
    .oSRAM_we_n      (oSRAM_we_n),
    .oRed            (oRed),
    .oGreen          (oGreen),
    .oBlue           (oBlue),
    .oBusy           (oBusy)
  );

  always #10 Clock = ~Clock;

  // SRAM contents: fixed words at 0..2, a scrambled pattern elsewhere.
  function automatic logic [15:0] sram_word(input logic [17:0] a);
    logic [15:0] h;
    case (a)
      18'd0: return 16'h1122;
      18'd1: return 16'h3344;
      18'd2: return 16'h5566;
      default: begin
        h = a[15:0] * 16'd40503;
        return h ^ {14'd0, a[17:16]} ^ 16'h5A3C;
      end
    endcase
  endfunction

  // Read port: data for an address launched at edge e is present at edge e+LAT.
  logic [17:0] ah [LAT];
  initial for (int i = 0; i < LAT; i++) ah[i] = '0;
  always @(negedge Clock) begin
    ah[0] <= oSRAM_address;
    for (int i = 1; i < LAT; i++) ah[i] <= ah[i-1];
  end
  assign iSRAM_read_data = sram_word(ah[LAT-1]);

  // ---------------- reference model ----------------
  int         m_t;            // edge of the last accepted trigger
  int         m_frow, m_fpair;
  int         m_ready_at [2];
  int         m_pair [2];
  int         m_row [2];
  logic       m_valid [2];
  int         m_prev_pair;
  logic [29:0] m_rgb;
  logic [17:0] m_addr;
  logic        m_busy;

  function automatic int word_addr(input int row, input int pair, input int w);
    return row * 480 + pair * 3 + w;
  endfunction

  function automatic logic [9:0] widen(input int c);
    return 10'((c * 4) + (c / 64));
  endfunction

  task automatic model_reset();
    m_t = -100; m_frow = 0; m_fpair = 0; m_prev_pair = 0;
    for (int s = 0; s < 2; s++) begin
      m_ready_at[s] = -1; m_valid[s] = 1'b0; m_pair[s] = 0; m_row[s] = 0;
    end
    m_rgb = '0; m_addr = '0; m_busy = 1'b0;
  endtask

  // Advance the model across one clock edge, given inputs held before the edge.
  task automatic model_edge(input logic en, input int x, input int y);
    int p, r, q, s, base, w0, w1, w2, cr, cg, cb, idx;
    logic trig;
    p = x / 4; r = y / 2; q = (p + 1) % 256; s = p % 2;
    m_rgb = '0;
    if (en && m_valid[s] && p < 160 && r < 240) begin
      base = word_addr(m_row[s], m_pair[s], 0);
      w0 = int'(sram_word(18'(base)));
      w1 = int'(sram_word(18'(base + 1)));
      w2 = int'(sram_word(18'(base + 2)));
      if ((x / 2) % 2 == 0) begin cr = w0 / 256; cg = w0 % 256; cb = w1 / 256; end
      else                  begin cr = w1 % 256; cg = w2 / 256; cb = w2 % 256; end
      m_rgb = {widen(cr), widen(cg), widen(cb)};
    end
`ifdef PIXEL_FETCH_COLOUR_BARS_EN
    else if (!en && x < 640 && y < 480) begin
      idx = x / 128;
      m_rgb = {(idx & 4) != 0 ? 10'h3FF : 10'h0, (idx & 2) != 0 ? 10'h3FF : 10'h0,
               (idx & 1) != 0 ? 10'h3FF : 10'h0};
    end
`else
    idx = 0;
`endif
    if (cyc >= m_t + 1 && cyc <= m_t + 3)
      m_addr = 18'(word_addr(m_frow, m_fpair, cyc - m_t - 1));
    for (int k = 0; k < 2; k++) begin
      if (!en) m_valid[k] = 1'b0;
      else if (m_ready_at[k] == cyc) m_valid[k] = 1'b1;
    end
    trig = en && (p != m_prev_pair) && (q < 160) && (r < 240) && (cyc >= m_t + 4);
    if (trig) begin
      m_t = cyc; m_frow = r; m_fpair = q;
      m_valid[q % 2] = 1'b0; m_ready_at[q % 2] = cyc + 6;
      m_pair[q % 2] = q; m_row[q % 2] = r;
    end
    m_prev_pair = p;
    m_busy = (cyc >= m_t) && (cyc <= m_t + 2);
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_model();
    check("rgb", {2'b0, oRed, oGreen, oBlue}, {2'b0, m_rgb});
    check("sram_addr", {14'd0, oSRAM_address}, {14'd0, m_addr});
    check("busy", {31'd0, oBusy}, {31'd0, m_busy});
    check("we_n", {31'd0, oSRAM_we_n}, 32'd1);
  endtask

  task automatic tick();
    logic en_s; int xs, ys;
    en_s = iEnable; xs = int'(iCoord_X); ys = int'(iCoord_Y);
    @(posedge Clock);
    cyc++;
    if (!Resetn) model_reset();
    else model_edge(en_s, xs, ys);
    #1;
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic async_reset();
    Resetn = 1'b0;
    #1;
    model_reset();
    check("rst_rgb", {2'b0, oRed, oGreen, oBlue}, 32'd0);
    check("rst_busy", {31'd0, oBusy}, 32'd0);
    check("rst_addr", {14'd0, oSRAM_address}, 32'd0);
  endtask

  typedef struct {
    int          x;
    logic        chk;
    logic [29:0] exp;
  } sweep_vec_t;

  sweep_vec_t vecs [8];

  initial begin
    int px;
    vecs[0] = '{1020, 1'b1, 30'd0};
    vecs[1] = '{1021, 1'b1, 30'd0};
    vecs[2] = '{1022, 1'b1, 30'd0};
    vecs[3] = '{1023, 1'b1, 30'd0};
    vecs[4] = '{0,    1'b1, {10'h044, 10'h088, 10'h0CC}};
    vecs[5] = '{1,    1'b1, {10'h044, 10'h088, 10'h0CC}};
    vecs[6] = '{2,    1'b1, {10'h111, 10'h155, 10'h199}};
    vecs[7] = '{3,    1'b1, {10'h111, 10'h155, 10'h199}};

    model_reset();
    // Reset values and quiet bus while disabled.
    #5;
    check("reset_rgb", {2'b0, oRed, oGreen, oBlue}, 32'd0);
    check("reset_we_n", {31'd0, oSRAM_we_n}, 32'd1);
    check("reset_busy", {31'd0, oBusy}, 32'd0);
    ticks(3);
    Resetn = 1'b1;
    ticks(6);
    check("idle_no_addr", {14'd0, oSRAM_address}, 32'd0);

    // Line sweep through blanking into pairs 0 and 1 of row 0.
    iEnable = 1'b1; iCoord_Y = 10'd0;
    foreach (vecs[i]) begin
      iCoord_X = 10'(vecs[i].x);
      ticks(2);
      if (vecs[i].chk) check($sformatf("sweep_x%0d", vecs[i].x),
                             {2'b0, oRed, oGreen, oBlue}, {2'b0, vecs[i].exp});
    end

    // Addressing: row 2, entering pair 9 fetches pair 10 at 990..992.
    iCoord_Y = 10'd5; iCoord_X = 10'd35; ticks(10);
    iCoord_X = 10'd36; tick();
    check("addr_busy", {31'd0, oBusy}, 32'd1);
    for (int w = 0; w < 3; w++) begin
      tick();
      check($sformatf("addr_w%0d", w), {14'd0, oSRAM_address}, 32'(990 + w));
    end

    // End of line: pair 159 is fetched, pair 160 is not, beyond is black.
    iCoord_X = 10'd631; ticks(10);
    iCoord_X = 10'd632; tick();
    for (int w = 0; w < 3; w++) begin
      tick();
      check($sformatf("eol_addr_w%0d", w), {14'd0, oSRAM_address}, 32'(960 + 477 + w));
    end
    ticks(4);
    iCoord_X = 10'd636;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("eol_no_fetch", {31'd0, oBusy}, 32'd0);
    end
    check("eol_addr_hold", {14'd0, oSRAM_address}, 32'd1439);
    iCoord_X = 10'd640; tick();
    check("past_image_black", {2'b0, oRed, oGreen, oBlue}, 32'd0);

    // iEnable dropped during R1: R2 still launches, output blanks at once.
    iCoord_Y = 10'd10; iCoord_X = 10'd99; ticks(10);
    iCoord_X = 10'd100; tick(); tick();
    iEnable = 1'b0; tick();
    check("drop_busy_r2", {31'd0, oBusy}, 32'd1);
    check("drop_black", {2'b0, oRed, oGreen, oBlue}, 32'd0);
    tick();
    check("drop_r2_addr", {14'd0, oSRAM_address}, 32'd2480);
    iEnable = 1'b1; tick();
    check("reenable_black", {2'b0, oRed, oGreen, oBlue}, 32'd0);
    for (int x = 101; x < 116; x++) begin
      iCoord_X = 10'(x); ticks(2);
    end

    // Disabled output: colour bars when built with them, black otherwise.
    iEnable = 1'b0; iCoord_X = 10'd300; iCoord_Y = 10'd100; tick();
`ifdef PIXEL_FETCH_COLOUR_BARS_EN
    check("bars_idx2", {2'b0, oRed, oGreen, oBlue}, {2'b0, 10'h0, 10'h3FF, 10'h0});
`else
    check("disabled_black", {2'b0, oRed, oGreen, oBlue}, 32'd0);
`endif

    // Randomized raster lines with enable toggles and one mid-fetch reset.
    iEnable = 1'b1;
    for (int line = 0; line < 5; line++) begin
      iCoord_Y = 10'($urandom_range(0, 520));
      for (int i = 0; i < 800; i++) begin
        px = (i < 160) ? (864 + i) : (i - 160);
        iCoord_X = 10'(px);
        if ($urandom_range(0, 199) == 0) iEnable = ~iEnable;
        if (line == 2 && i == 300) begin
          tick();
          async_reset();
          ticks(2);
          Resetn = 1'b1;
          tick();
        end else begin
          ticks(2);
        end
      end
      iEnable = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
